// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: FSM encoding, per-stage control bundle, defaults.
// Optional performance counters in the top are enabled by defining PIPE_PERF_COUNTERS_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_we;
  } stage_ctrl_t;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

  // Field order: pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we
  localparam stage_ctrl_t CTRL_NORMAL   = stage_ctrl_t'(6'b110011);
  localparam stage_ctrl_t CTRL_FREEZE   = stage_ctrl_t'(6'b000000);
  localparam stage_ctrl_t CTRL_BRANCH   = stage_ctrl_t'(6'b111111);
  localparam stage_ctrl_t CTRL_LOAD_USE = stage_ctrl_t'(6'b000111);
  localparam stage_ctrl_t CTRL_RESET    = stage_ctrl_t'(6'b010011);

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage control outputs of the stall controller, grouped as one bundle.
// master = pipeline side raising hazards, slave = the controller.
interface pipeline_stall_controller_if #(
  parameter int PERF_W = 32
);
  logic              load_hazard;
  logic              branch_taken;
  logic              imem_busy;
  logic              dmem_busy;
  logic              pc_write_en;
  logic              if_id_write_en;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_mem_write_en;
  logic              mem_wb_write_en;
  logic              wb_forward_hint;
  logic              wd_timeout;
  logic [1:0]        ctrl_state;
  logic [PERF_W-1:0] bubble_cnt;
  logic [PERF_W-1:0] flush_cnt;
  logic [PERF_W-1:0] memstall_cnt;

  modport master (
    output load_hazard, branch_taken, imem_busy, dmem_busy,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           ex_mem_write_en, mem_wb_write_en, wb_forward_hint, wd_timeout,
           ctrl_state, bubble_cnt, flush_cnt, memstall_cnt
  );

  modport slave (
    input  load_hazard, branch_taken, imem_busy, dmem_busy,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           ex_mem_write_en, mem_wb_write_en, wb_forward_hint, wd_timeout,
           ctrl_state, bubble_cnt, flush_cnt, memstall_cnt
  );
endinterface

// File: rtl/pipeline_stall_controller_watchdog.sv
// Memory-wait watchdog: counts consecutive busy cycles, saturates at MEM_TIMEOUT,
// and pulses fire in the cycle whose count reaches the limit.
module mem_wait_watchdog #(
  parameter int WD_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic fire
);
  localparam logic [WD_W-1:0] LIMIT = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] ONE   = WD_W'(1);

  logic [WD_W-1:0] count_reg;
  logic [WD_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_en && (count_reg != LIMIT)) begin
      count_next = count_reg + ONE;
    end
  end

  // Compare against the next value so the cycle that completes the limit raises the error
  assign fire = count_en && (count_next == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/pipeline_stall_controller.sv
// Central hold/flush/bubble sequencer for the 5-stage pipeline with a memory-wait watchdog.
// Define PIPE_PERF_COUNTERS_EN to build the bubble/flush/memstall performance counters.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int WD_W        = 8,
  parameter int PERF_W      = 32
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_stall_controller_if.slave  bus
);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  logic        wd_timeout_reg;
  logic        wd_timeout_next;
  logic        wd_fire;
  logic        busy;
  logic        halted;
  stage_ctrl_t ctrl;
  logic        hint;

  assign busy   = bus.imem_busy | bus.dmem_busy;
  assign halted = (state_reg == ST_HALT);

  mem_wait_watchdog #(
    .WD_W        (WD_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .count_en (busy & ~halted),
    .clear    (~busy),
    .fire     (wd_fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_RUN;
      wd_timeout_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wd_timeout_reg <= wd_timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wd_timeout_next = wd_timeout_reg | wd_fire;
    case (state_reg)
      ST_HALT: state_next = ST_HALT;
      default: begin
        if (busy) begin
          state_next = wd_fire ? ST_HALT : ST_MEM_WAIT;
        end else if (bus.branch_taken) begin
          state_next = ST_RUN;
        end else if (bus.load_hazard && (state_reg != ST_BUBBLE)) begin
          state_next = ST_BUBBLE;
        end else begin
          state_next = ST_RUN;
        end
      end
    endcase
  end

  // A BUBBLE cycle masks load_hazard: the stalled instruction already got its one bubble
  always_comb begin
    ctrl = CTRL_NORMAL;
    hint = 1'b0;
    if (!reset) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_reg)
        ST_HALT: ctrl = CTRL_FREEZE;
        default: begin
          hint = (state_reg == ST_BUBBLE);
          if (busy) begin
            ctrl = CTRL_FREEZE;
          end else if (bus.branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (bus.load_hazard && (state_reg != ST_BUBBLE)) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
      endcase
    end
  end

  assign bus.pc_write_en     = ctrl.pc_we;
  assign bus.if_id_write_en  = ctrl.ifid_we;
  assign bus.if_id_flush     = ctrl.ifid_flush;
  assign bus.id_ex_bubble    = ctrl.idex_bubble;
  assign bus.ex_mem_write_en = ctrl.exmem_we;
  assign bus.mem_wb_write_en = ctrl.memwb_we;
  assign bus.wb_forward_hint = hint;
  assign bus.wd_timeout      = wd_timeout_reg;
  assign bus.ctrl_state      = state_reg;

`ifdef PIPE_PERF_COUNTERS_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  logic [2:0]             perf_inc;
  logic [2:0][PERF_W-1:0] perf_cnt;

  // Index 0: load-use bubble (branch bubbles carry a flush), 1: flush, 2: memory freeze
  assign perf_inc[0] = ctrl.idex_bubble & ~ctrl.ifid_flush;
  assign perf_inc[1] = ctrl.ifid_flush;
  assign perf_inc[2] = reset & ~halted & (ctrl == CTRL_FREEZE);

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [PERF_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + PERF_ONE;
      end
    end

    assign perf_cnt[gi] = cnt_reg;
  end

  assign bus.bubble_cnt   = perf_cnt[0];
  assign bus.flush_cnt    = perf_cnt[1];
  assign bus.memstall_cnt = perf_cnt[2];
`else
  localparam logic [PERF_W-1:0] PERF_ZERO = '0;

  assign bus.bubble_cnt   = PERF_ZERO;
  assign bus.flush_cnt    = PERF_ZERO;
  assign bus.memstall_cnt = PERF_ZERO;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=4); control vector packs
// {pc_we, ifid_we, flush, bubble, exmem_we, memwb_we, wb_forward_hint}.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.PERF_W(32)) bus ();

  pipeline_stall_controller #(
    .MEM_TIMEOUT (4),
    .WD_W        (8),
    .PERF_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [6:0] obs_ctrl();
    return {bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush, bus.id_ex_bubble,
            bus.ex_mem_write_en, bus.mem_wb_write_en, bus.wb_forward_hint};
  endfunction

  task automatic drive(input logic lh, input logic bt, input logic ib, input logic db);
    bus.load_hazard  = lh;
    bus.branch_taken = bt;
    bus.imem_busy    = ib;
    bus.dmem_busy    = db;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b0100110) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", obs_ctrl(), 7'b0100110);
    end
    checks++;
    if (bus.ctrl_state !== 2'd0 || bus.wd_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_state got=%0d/%b exp=0/0", bus.ctrl_state, bus.wd_timeout);
    end
    step(); step();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b1100110) begin
      failures++; $display("FAIL idle_ctrl got=%b exp=%b", obs_ctrl(), 7'b1100110);
    end
    step();
    checks++;
    if (bus.ctrl_state !== 2'd0) begin
      failures++; $display("FAIL idle_state got=%0d exp=0", bus.ctrl_state);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b0001110) begin
      failures++; $display("FAIL load_use_c1 got=%b exp=%b", obs_ctrl(), 7'b0001110);
    end
    step();
    drive(1, 0, 0, 0);
    checks++;
    if (bus.ctrl_state !== 2'd1) begin
      failures++; $display("FAIL load_use_bubble_state got=%0d exp=1", bus.ctrl_state);
    end
    checks++;
    if (obs_ctrl() !== 7'b1100111) begin
      failures++; $display("FAIL load_use_c2_masked got=%b exp=%b", obs_ctrl(), 7'b1100111);
    end
    step();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.ctrl_state !== 2'd0 || obs_ctrl() !== 7'b1100110) begin
      failures++; $display("FAIL load_use_c3 got=%0d/%b exp=0/%b", bus.ctrl_state, obs_ctrl(), 7'b1100110);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    drive(1, 1, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b1111110) begin
      failures++; $display("FAIL branch_ctrl got=%b exp=%b", obs_ctrl(), 7'b1111110);
    end
    step();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.ctrl_state !== 2'd0) begin
      failures++; $display("FAIL branch_state got=%0d exp=0", bus.ctrl_state);
    end
    $display("test_branch done");
  endtask

  task automatic test_mem_busy();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 1);
      checks++;
      if (obs_ctrl() !== 7'b0000000) begin
        failures++; $display("FAIL mem_busy_freeze c=%0d got=%b exp=%b", c, obs_ctrl(), 7'b0000000);
      end
      step();
      checks++;
      if (bus.ctrl_state !== 2'd2) begin
        failures++; $display("FAIL mem_busy_state c=%0d got=%0d exp=2", c, bus.ctrl_state);
      end
    end
    drive(0, 1, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b1111110) begin
      failures++; $display("FAIL mem_release_branch got=%b exp=%b", obs_ctrl(), 7'b1111110);
    end
    step();
    drive(0, 0, 0, 0);
    checks++;
    if (bus.ctrl_state !== 2'd0 || bus.wd_timeout !== 1'b0) begin
      failures++; $display("FAIL mem_release_state got=%0d/%b exp=0/0", bus.ctrl_state, bus.wd_timeout);
    end
`ifdef PIPE_PERF_COUNTERS_EN
    checks++;
    if (bus.memstall_cnt !== 32'd3 || bus.flush_cnt !== 32'd2 || bus.bubble_cnt !== 32'd1) begin
      failures++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=3/2/1",
                           bus.memstall_cnt, bus.flush_cnt, bus.bubble_cnt);
    end
`else
    checks++;
    if (bus.memstall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0 || bus.bubble_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_tied_zero got=%0d/%0d/%0d exp=0/0/0",
                           bus.memstall_cnt, bus.flush_cnt, bus.bubble_cnt);
    end
`endif
    $display("test_mem_busy done");
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 1, 0);
      checks++;
      if (obs_ctrl() !== 7'b0000000) begin
        failures++; $display("FAIL timeout_freeze c=%0d got=%b exp=%b", c, obs_ctrl(), 7'b0000000);
      end
      step();
      checks++;
      if (bus.wd_timeout !== (c == 4) || bus.ctrl_state !== ((c == 4) ? 2'd3 : 2'd2)) begin
        failures++; $display("FAIL timeout_progress c=%0d got=%0d/%b exp=%0d/%b", c,
                             bus.ctrl_state, bus.wd_timeout, (c == 4) ? 3 : 2, (c == 4));
      end
    end
    drive(0, 1, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b0000000) begin
      failures++; $display("FAIL halt_freeze got=%b exp=%b", obs_ctrl(), 7'b0000000);
    end
    step();
    #2;
    checks++;
    if (bus.ctrl_state !== 2'd3 || bus.wd_timeout !== 1'b1) begin
      failures++; $display("FAIL halt_persist got=%0d/%b exp=3/1", bus.ctrl_state, bus.wd_timeout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.ctrl_state !== 2'd0 || bus.wd_timeout !== 1'b0 || obs_ctrl() !== 7'b0100110) begin
      failures++; $display("FAIL halt_async_reset got=%0d/%b/%b exp=0/0/%b",
                           bus.ctrl_state, bus.wd_timeout, obs_ctrl(), 7'b0100110);
    end
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    checks++;
    if (obs_ctrl() !== 7'b1100110) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=%b", obs_ctrl(), 7'b1100110);
    end
    $display("test_timeout done");
  endtask

  initial begin
    bus.load_hazard  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.imem_busy    = 1'b0;
    bus.dmem_busy    = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_busy();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage RISC-V pipeline's hold, flush and bubble controls.
- Arbitrates between four stall sources:
  - load-use hazard request from the hazard detect units;
  - EX-stage taken branch/jump redirect;
  - instruction memory busy;
  - data memory busy.
- Drives per-stage register enables, the IF/ID flush and the ID/EX bubble.
- Runs a memory-wait watchdog that halts the core on a hung memory.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive busy cycles before the watchdog fires; range 1..2^WD_W-1.
- WD_W, 8: watchdog counter width.
- PERF_W, 32: performance counter width; used only with the optional feature.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_hazard  in  1  ID instruction depends on a load currently in EX.
- branch_taken  in  1  EX stage resolved a taken branch/jump this cycle.
- imem_busy  in  1  instruction memory cannot complete a fetch this cycle.
- dmem_busy  in  1  data memory cannot complete an access this cycle.
- pc_write_en  out  1  PC register update enable.
- if_id_write_en  out  1  IF/ID register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_bubble  out  1  load NOP controls into ID/EX.
- ex_mem_write_en  out  1  EX/MEM register enable.
- mem_wb_write_en  out  1  MEM/WB register enable.
- wb_forward_hint  out  1  high in the cycle after a load bubble; the EX operand comes from WB.
- wd_timeout  out  1  sticky watchdog error.
- ctrl_state  out  2  current FSM state, for debug.
- bubble_cnt, flush_cnt, memstall_cnt  out  PERF_W each  performance counters (optional feature).

Behaviour:
- FSM states: RUN=0, BUBBLE=1, MEM_WAIT=2, HALT=3.
- State, watchdog counter and wd_timeout are registered.
- Control outputs are combinational from state and inputs, so stalls take effect in the same cycle (zero latency).
- Reset (reset=0, async): state=RUN, watchdog=0, wd_timeout=0.
  - Control outputs while in reset: pc_write_en=0, all other write enables=1, if_id_flush=0, id_ex_bubble=0, wb_forward_hint=0.
  - Reset takes effect mid-stall from any state.
- Priority is HALT > memory busy > branch_taken > load_hazard.
- Memory busy (RUN or BUBBLE, imem_busy|dmem_busy=1):
  - all five enables=0; flush=0, bubble=0;
  - next state MEM_WAIT, watchdog=1.
- MEM_WAIT:
  - While busy: full freeze, watchdog increments.
  - Watchdog reaching MEM_TIMEOUT while still busy: next state HALT, wd_timeout=1.
  - Busy deasserted: evaluate branch/load rules for this same cycle as in RUN; next state per those rules; watchdog cleared.
  - Hazard inputs need no capture: frozen registers keep them valid.
- Branch (RUN, not busy, branch_taken=1):
  - pc_write_en=1, if_id_flush=1, id_ex_bubble=1, other enables=1;
  - load_hazard ignored (wrong-path instruction); state stays RUN.
- Load-use (RUN, not busy, no branch, load_hazard=1):
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, ex_mem/mem_wb enables=1;
  - next state BUBBLE.
- BUBBLE:
  - load_hazard masked (exactly one bubble per load);
  - wb_forward_hint=1; normal enables unless busy or branch;
  - next state RUN, or MEM_WAIT on busy.
- HALT:
  - all enables=0, flush=0, bubble=0;
  - exits only on reset.
- Watchdog saturates at MEM_TIMEOUT; never wraps.

Optional Feature:
- Macro: PIPE_PERF_COUNTERS_EN.
- Defined: bubble_cnt, flush_cnt and memstall_cnt count cycles with id_ex_bubble from load-use, if_id_flush, and full freeze respectively.
  - Each counter saturates at all-ones and clears on reset.
  - HALT cycles are not counted.
- Undefined: the counter ports stay present and are tied to 0; no counter flops.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum and encodings (RUN/BUBBLE/MEM_WAIT/HALT);
  - a stage_ctrl struct (pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we);
  - the default MEM_TIMEOUT constant.
- One sub-module, mem_wait_watchdog: counter, saturation, and compare producing the timeout pulse.

Test Plan:
- Reset released, all inputs 0 -> all enables=1, flush=0, bubble=0, ctrl_state=0.
- load_hazard=1 for 2 cycles -> cycle 1: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1; cycle 2: state BUBBLE, hazard masked, wb_forward_hint=1, enables=1; cycle 3: RUN.
- branch_taken=1 with load_hazard=1 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1; state stays RUN.
- dmem_busy=1 for 3 cycles with branch_taken=1 held -> 3 cycles all enables=0; on release, flush+bubble asserted in the same cycle; memstall_cnt=3 with the feature enabled.
- MEM_TIMEOUT=4, imem_busy held -> wd_timeout=1 after the 4th busy cycle; state HALT persists with busy dropped; reset=0 mid-HALT -> RUN, wd_timeout=0 immediately.
